// File: rtl/mc_controller.sv
// Multicycle MIPS-style control FSM (lw, sw, R-type, beq, addi, j).
// Define MC_MEMWAIT_EN to add mem_ready wait states, a wait-cycle timeout and the sticky mem_err flag.
module mc_controller #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcen,
    output logic       irwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
`ifdef MC_MEMWAIT_EN
    output logic       illegal,
    output logic       mem_err
`else
    output logic       illegal
`endif
);

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXECUTE,
        ALUWB,
        BRANCH,
        ADDIEX,
        ADDIWB,
        JUMP
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t state;
    logic   mem_go;
    logic   mem_state;
    logic   hold;
    logic   pcwrite;

`ifdef MC_MEMWAIT_EN
    logic [7:0] wait_cnt;
    logic       timeout;

    assign mem_go  = mem_ready;
    assign timeout = (wait_cnt == 8'(WAIT_MAX - 1));
`else
    // Without wait states memory is always ready; the expression keeps the
    // unused port and parameter referenced and folds to constant 1.
    assign mem_go = mem_ready | (WAIT_MAX > 0);
`endif

    assign mem_state = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
    assign hold      = mem_state && !mem_go;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else if (hold) begin
`ifdef MC_MEMWAIT_EN
            if (timeout) begin
                state <= FETCH;
            end
`endif
        end else begin
            case (state)
                FETCH:   state <= DECODE;
                DECODE: begin
                    case (op)
                        OP_LW, OP_SW: state <= MEMADR;
                        OP_RTYP:      state <= EXECUTE;
                        OP_BEQ:       state <= BRANCH;
                        OP_ADDI:      state <= ADDIEX;
                        OP_J:         state <= JUMP;
                        default:      state <= FETCH;
                    endcase
                end
                MEMADR:  state <= (op == OP_SW) ? MEMWR : MEMRD;
                MEMRD:   state <= MEMWB;
                MEMWB:   state <= FETCH;
                MEMWR:   state <= FETCH;
                EXECUTE: state <= ALUWB;
                ALUWB:   state <= FETCH;
                BRANCH:  state <= FETCH;
                ADDIEX:  state <= ADDIWB;
                ADDIWB:  state <= FETCH;
                JUMP:    state <= FETCH;
                default: state <= FETCH;
            endcase
        end
    end

`ifdef MC_MEMWAIT_EN
    // Counter restarts after every completed or abandoned access.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else if (hold) begin
            if (timeout) begin
                wait_cnt <= '0;
                mem_err  <= 1'b1;
            end else begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end else begin
            wait_cnt <= '0;
        end
    end
`endif

    always_comb begin
        pcwrite    = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = 3'b000;
        illegal    = 1'b0;
        pcen       = 1'b0;
        case (state)
            FETCH: begin
                irwrite    = !hold;
                pcwrite    = !hold;
                alusrcb    = 2'b01;
                alucontrol = ALU_ADD;
            end
            DECODE: begin
                alusrcb    = 2'b11;
                alucontrol = ALU_ADD;
                illegal    = !(op == OP_LW || op == OP_SW || op == OP_RTYP ||
                               op == OP_BEQ || op == OP_ADDI || op == OP_J);
            end
            MEMADR, ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = ALU_ADD;
            end
            MEMRD: begin
                iord = 1'b1;
            end
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = !hold;
            end
            EXECUTE: begin
                alusrca = 1'b1;
                case (funct)
                    6'b100010: alucontrol = ALU_SUB;
                    6'b100100: alucontrol = ALU_AND;
                    6'b100101: alucontrol = ALU_OR;
                    6'b101010: alucontrol = ALU_SLT;
                    default:   alucontrol = ALU_ADD;
                endcase
            end
            ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
            end
            ADDIWB: begin
                regwrite = 1'b1;
            end
            JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: begin
            end
        endcase
        pcen = pcwrite || ((state == BRANCH) && zero);
    end

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: stimulus pushes hand-computed output vectors, a negedge monitor pops and compares.
// Wait-state and timeout sequences run only when MC_MEMWAIT_EN is defined.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pcen, irwrite, regwrite, memwrite, iord, memtoreg, regdst, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       illegal;
`ifdef MC_MEMWAIT_EN
    logic       mem_err;
    localparam logic RDY_IDLE = 1'b1;
`else
    localparam logic RDY_IDLE = 1'b0;
`endif

    always #5 clk = ~clk;

    mc_controller #(.WAIT_MAX(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite),
        .memwrite(memwrite), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
        .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
`ifdef MC_MEMWAIT_EN
        .illegal(illegal), .mem_err(mem_err)
`else
        .illegal(illegal)
`endif
    );

    // Vector layout: {pcen,irwrite,regwrite,memwrite,iord,memtoreg,regdst,alusrca, alusrcb, pcsrc, alucontrol, illegal}
    localparam logic [15:0] V_FETCH    = {8'b1100_0000, 2'b01, 2'b00, 3'b010, 1'b0};
    localparam logic [15:0] V_DECODE   = {8'b0000_0000, 2'b11, 2'b00, 3'b010, 1'b0};
    localparam logic [15:0] V_DEC_ILL  = {8'b0000_0000, 2'b11, 2'b00, 3'b010, 1'b1};
    localparam logic [15:0] V_MEMADR   = {8'b0000_0001, 2'b10, 2'b00, 3'b010, 1'b0};
    localparam logic [15:0] V_MEMRD    = {8'b0000_1000, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [15:0] V_MEMWB    = {8'b0010_0100, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [15:0] V_MEMWR    = {8'b0001_1000, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [15:0] V_EX_ADD   = {8'b0000_0001, 2'b00, 2'b00, 3'b010, 1'b0};
    localparam logic [15:0] V_EX_SUB   = {8'b0000_0001, 2'b00, 2'b00, 3'b110, 1'b0};
    localparam logic [15:0] V_EX_AND   = {8'b0000_0001, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [15:0] V_EX_OR    = {8'b0000_0001, 2'b00, 2'b00, 3'b001, 1'b0};
    localparam logic [15:0] V_EX_SLT   = {8'b0000_0001, 2'b00, 2'b00, 3'b111, 1'b0};
    localparam logic [15:0] V_ALUWB    = {8'b0010_0010, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [15:0] V_BR_TAKEN = {8'b1000_0001, 2'b00, 2'b01, 3'b110, 1'b0};
    localparam logic [15:0] V_BR_NOT   = {8'b0000_0001, 2'b00, 2'b01, 3'b110, 1'b0};
    localparam logic [15:0] V_ADDIWB   = {8'b0010_0000, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [15:0] V_JUMP     = {8'b1000_0000, 2'b00, 2'b10, 3'b000, 1'b0};
`ifdef MC_MEMWAIT_EN
    localparam logic [15:0] V_FETCH_HOLD = {8'b0000_0000, 2'b01, 2'b00, 3'b010, 1'b0};
    localparam logic [15:0] V_MEMWR_HOLD = {8'b0000_1000, 2'b00, 2'b00, 3'b000, 1'b0};
`endif

    typedef struct {
        logic [15:0] v;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    wire [15:0] got = {pcen, irwrite, regwrite, memwrite, iord, memtoreg, regdst, alusrca,
                       alusrcb, pcsrc, alucontrol, illegal};

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            n_vec++;
            if (got !== e.v) begin
                n_bad++;
                $display("FAIL %s: got %b required %b", e.nm, got, e.v);
            end
        end
    end

    // Expect v for the current cycle, then move to the next cycle.
    task automatic chk(input logic [15:0] v, input string nm);
        exp_t e;
        e.v  = v;
        e.nm = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [5:0] o, input logic [5:0] f, input logic z);
        op    = o;
        funct = f;
        zero  = z;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        mem_ready = RDY_IDLE;
        set_instr(6'b000000, 6'b000000, 1'b0);
        @(posedge clk);
        #1;
        chk(V_FETCH, "reset_state");
        reset = 1'b0;

        set_instr(6'b100011, 6'b000000, 1'b0);
        chk(V_FETCH, "lw_fetch_after_reset");
        chk(V_DECODE, "lw_decode");
        chk(V_MEMADR, "lw_memadr");
        chk(V_MEMRD, "lw_memrd");
        chk(V_MEMWB, "lw_memwb");

        set_instr(6'b101011, 6'b000000, 1'b0);
        chk(V_FETCH, "sw_fetch");
        chk(V_DECODE, "sw_decode");
        chk(V_MEMADR, "sw_memadr");
        chk(V_MEMWR, "sw_memwr");

        set_instr(6'b000000, 6'b101010, 1'b0);
        chk(V_FETCH, "slt_fetch");
        chk(V_DECODE, "slt_decode");
        chk(V_EX_SLT, "slt_execute");
        chk(V_ALUWB, "slt_aluwb");

        set_instr(6'b000000, 6'b100010, 1'b0);
        chk(V_FETCH, "sub_fetch");
        chk(V_DECODE, "sub_decode");
        chk(V_EX_SUB, "sub_execute");
        chk(V_ALUWB, "sub_aluwb");

        set_instr(6'b000000, 6'b100100, 1'b1);
        chk(V_FETCH, "and_fetch");
        chk(V_DECODE, "and_decode");
        chk(V_EX_AND, "and_execute");
        chk(V_ALUWB, "and_aluwb");

        set_instr(6'b000000, 6'b100101, 1'b0);
        chk(V_FETCH, "or_fetch");
        chk(V_DECODE, "or_decode");
        chk(V_EX_OR, "or_execute");
        chk(V_ALUWB, "or_aluwb");

        set_instr(6'b000000, 6'b100000, 1'b0);
        chk(V_FETCH, "add_fetch");
        chk(V_DECODE, "add_decode");
        chk(V_EX_ADD, "add_execute");
        chk(V_ALUWB, "add_aluwb");

        set_instr(6'b000000, 6'b111111, 1'b0);
        chk(V_FETCH, "badfunct_fetch");
        chk(V_DECODE, "badfunct_decode");
        chk(V_EX_ADD, "badfunct_execute_add");
        chk(V_ALUWB, "badfunct_aluwb");

        set_instr(6'b000100, 6'b000000, 1'b1);
        chk(V_FETCH, "beq_t_fetch");
        chk(V_DECODE, "beq_t_decode");
        chk(V_BR_TAKEN, "beq_t_branch");

        set_instr(6'b000100, 6'b000000, 1'b0);
        chk(V_FETCH, "beq_nt_fetch");
        chk(V_DECODE, "beq_nt_decode");
        chk(V_BR_NOT, "beq_nt_branch");

        set_instr(6'b001000, 6'b000000, 1'b1);
        chk(V_FETCH, "addi_fetch");
        chk(V_DECODE, "addi_decode");
        chk(V_MEMADR, "addi_addiex");
        chk(V_ADDIWB, "addi_addiwb");

        set_instr(6'b000010, 6'b000000, 1'b0);
        chk(V_FETCH, "j_fetch");
        chk(V_DECODE, "j_decode");
        chk(V_JUMP, "j_jump");

        set_instr(6'b111111, 6'b000000, 1'b1);
        chk(V_FETCH, "ill_fetch");
        chk(V_DEC_ILL, "ill_decode");

        set_instr(6'b001101, 6'b000000, 1'b0);
        chk(V_FETCH, "ill2_fetch");
        chk(V_DEC_ILL, "ill2_decode");

        // Reset asserted in the middle of a load.
        set_instr(6'b100011, 6'b000000, 1'b0);
        chk(V_FETCH, "midrst_fetch");
        chk(V_DECODE, "midrst_decode");
        reset = 1'b1;
        chk(V_MEMADR, "midrst_memadr");
        reset = 1'b0;
        set_instr(6'b000010, 6'b000000, 1'b0);
        chk(V_FETCH, "midrst_back_to_fetch");
        chk(V_DECODE, "post_rst_j_decode");
        chk(V_JUMP, "post_rst_j_jump");

`ifdef MC_MEMWAIT_EN
        set_instr(6'b101011, 6'b000000, 1'b0);
        mem_ready = 1'b1;
        chk(V_FETCH, "wsw_fetch");
        chk(V_DECODE, "wsw_decode");
        chk(V_MEMADR, "wsw_memadr");
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) chk(V_MEMWR_HOLD, "wsw_memwr_hold");
        mem_ready = 1'b1;
        chk(V_MEMWR, "wsw_memwr_go");

        set_instr(6'b100011, 6'b000000, 1'b0);
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) chk(V_FETCH_HOLD, "tmo_fetch_hold");
        n_vec++;
        if (mem_err !== 1'b1) begin
            n_bad++;
            $display("FAIL mem_err_set: got %b required 1", mem_err);
        end
        reset = 1'b1;
        chk(V_FETCH_HOLD, "tmo_hold_before_reset");
        reset     = 1'b0;
        mem_ready = 1'b1;
        n_vec++;
        if (mem_err !== 1'b0) begin
            n_bad++;
            $display("FAIL mem_err_cleared: got %b required 0", mem_err);
        end
        chk(V_FETCH, "post_tmo_fetch");
        chk(V_DECODE, "post_tmo_decode");
`endif

        @(negedge clk);
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter WAIT_MAX, default 15: maximum memory wait cycles before timeout; legal range 1..255; used only when MC_MEMWAIT_EN is defined.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 op  input  6  instruction opcode taken from the instruction register.
REQ-005 funct  input  6  R-type function field.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 mem_ready  input  1  memory access complete; ignored when MC_MEMWAIT_EN is not defined.
REQ-008 pcen  output  1  PC register load enable; equals pcwrite OR (branch state AND zero).
REQ-009 irwrite, regwrite, memwrite, iord, memtoreg, regdst, alusrca  output  1 each  standard multicycle datapath strobes and selects.
REQ-010 alusrcb  output  2  ALU B select: 00 reg, 01 constant 4, 10 sign-extended immediate, 11 shifted immediate.
REQ-011 pcsrc  output  2  next-PC select: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-012 alucontrol  output  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-013 illegal  output  1  one-cycle pulse for an unsupported opcode.
REQ-014 mem_err  output  1  sticky memory timeout flag; present only with MC_MEMWAIT_EN.

Function
REQ-015 The FSM SHALL have the states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB and JUMP.
REQ-016 FETCH SHALL assert iord=0, irwrite=1, alusrca=0, alusrcb=01, ALU add, pcsrc=00 and pcwrite=1, then go to DECODE.
REQ-017 DECODE SHALL select alusrca=0, alusrcb=11 and ALU add, then branch on op: 100011/101011 to MEMADR, 000000 to EXECUTE, 000100 to BRANCH, 001000 to ADDIEX, 000010 to JUMP, and any other value to FETCH.
REQ-018 An unsupported opcode SHALL assert illegal combinationally for the DECODE cycle only.
REQ-019 MEMADR SHALL select alusrca=1, alusrcb=10 and ALU add, then go to MEMRD for lw or to MEMWR for sw.
REQ-020 MEMRD SHALL assert iord=1, then go to MEMWB.
REQ-021 MEMWB SHALL assert regdst=0, memtoreg=1 and regwrite=1, then go to FETCH.
REQ-022 MEMWR SHALL assert iord=1 and memwrite=1, then go to FETCH.
REQ-023 EXECUTE SHALL select alusrca=1 and alusrcb=00, with alucontrol decoded from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, and any other funct add.
REQ-024 EXECUTE SHALL then go to ALUWB.
REQ-025 ALUWB SHALL assert regdst=1, memtoreg=0 and regwrite=1, then go to FETCH.
REQ-026 BRANCH SHALL select alusrca=1, alusrcb=00, ALU sub and pcsrc=01, drive pcen=zero, then go to FETCH.
REQ-027 ADDIEX SHALL select alusrca=1, alusrcb=10 and ALU add, then go to ADDIWB; ADDIWB SHALL assert regdst=0, memtoreg=0 and regwrite=1, then go to FETCH.
REQ-028 JUMP SHALL assert pcsrc=10 and pcwrite=1, then go to FETCH.
REQ-029 Every strobe not listed for a state SHALL be 0; select lines not listed SHALL be 0.
REQ-030 Cycles per instruction without waits SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.

Reset
REQ-031 With reset high at a rising edge, the state SHALL become FETCH, and the wait counter and mem_err SHALL become 0.
REQ-032 Reset SHALL take priority over every transition, including a reset asserted mid-instruction or mid-wait.
REQ-033 In the first cycle after reset releases, the outputs SHALL be the FETCH values: pcen=1 and irwrite=1.

Configuration
REQ-034 With MC_MEMWAIT_EN defined, FETCH, MEMRD and MEMWR SHALL hold while mem_ready=0.
REQ-035 During such a hold, the FSM SHALL keep iord and the address selects, and gate irwrite, pcwrite and memwrite to 0.
REQ-036 Under MC_MEMWAIT_EN, the state SHALL advance and the strobes SHALL assert in the first cycle where mem_ready=1.
REQ-037 Under MC_MEMWAIT_EN, an 8-bit counter SHALL count the wait cycles; on reaching WAIT_MAX, the FSM SHALL set mem_err, abandon the access and go to FETCH.
REQ-038 Under MC_MEMWAIT_EN, mem_err SHALL be cleared only by reset.
REQ-039 Without MC_MEMWAIT_EN, mem_ready SHALL be ignored, every state SHALL last exactly one cycle, and mem_err SHALL be absent.

Verification
REQ-040 Reset for 2 cycles, then op=100011 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 and memtoreg=1 in cycle 5 only.
REQ-041 op=000100 with zero=1 -> pcen=1 and pcsrc=01 in cycle 3; repeat with zero=0 -> pcen=0 in cycle 3.
REQ-042 op=000000 with funct=101010 -> alucontrol=111 in EXECUTE; regdst=1 and regwrite=1 in ALUWB; 4 cycles total.
REQ-043 op=111111 -> illegal=1 in DECODE only; next state FETCH; no regwrite, memwrite or pcen in DECODE.
REQ-044 MC_MEMWAIT_EN with sw and mem_ready low for 3 cycles in MEMWR -> memwrite=0 for those 3 cycles, then memwrite=1 for 1 cycle.
REQ-045 MC_MEMWAIT_EN with WAIT_MAX=4 and mem_ready stuck at 0 in FETCH -> mem_err=1 after 4 wait cycles; reset then clears mem_err.
